// File: rtl/arb_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_D  = 2'd2
  } arb_state_t;

  localparam logic [2:0] FUNCT3_WORD      = 3'b010;
  localparam int         STARVE_LIMIT_DEF = 4;
  localparam int         TIMEOUT_DEF      = 255;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; used for arbiter bookkeeping.
module arb_sat_counter #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter for a single-ported unified memory with starvation guard and timeout.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        cpu_stall,
  output logic [31:0] perf_if_cnt,
  output logic [31:0] perf_d_cnt,
  output logic [31:0] perf_stall_cnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t    state;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    funct3_q;
  logic          we_q;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          busy;
  logic          starved;
  logic          d_win;
  logic          if_win;
  logic          tmo_hit;
  logic          done;

  assign busy    = (state != ARB_IDLE);
  assign starved = if_req && (starve_cnt == SW'(STARVE_LIMIT));
  // Grants are combinational, so they are masked while reset holds the FSM.
  assign d_win   = n_rst && !busy && d_req && !starved;
  assign if_win  = n_rst && !busy && if_req && !d_win;
  assign d_gnt   = d_win;
  assign if_gnt  = if_win;

  assign tmo_hit = busy && !mem_ready && (tmo_cnt == TW'(TIMEOUT - 1));
  assign done    = busy && (mem_ready || tmo_hit);

  // The memory only ever sees the captured request, never the live ports.
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_funct3 = funct3_q;
  assign mem_we     = mem_req & we_q;

  assign cpu_stall = (if_req & ~if_rvalid) | (d_req & ~d_rvalid);

  arb_sat_counter #(.WIDTH(SW), .MAX(SW'(STARVE_LIMIT))) u_starve (
    .clk(clk), .n_rst(n_rst), .clr(!if_req || if_win), .inc(d_win), .cnt(starve_cnt)
  );

  arb_sat_counter #(.WIDTH(TW), .MAX(TW'(TIMEOUT))) u_tmo (
    .clk(clk), .n_rst(n_rst), .clr(!busy), .inc(busy && !mem_ready), .cnt(tmo_cnt)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ARB_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      we_q      <= 1'b0;
      mem_req   <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_err   <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (d_win) begin
            addr_q   <= d_addr;
            wdata_q  <= d_wdata;
            funct3_q <= d_funct3;
            we_q     <= d_we;
            mem_req  <= 1'b1;
            state    <= ARB_BUSY_D;
          end else if (if_win) begin
            addr_q   <= if_addr;
            wdata_q  <= '0;
            funct3_q <= FUNCT3_WORD;
            we_q     <= 1'b0;
            mem_req  <= 1'b1;
            state    <= ARB_BUSY_IF;
          end
        end
        ARB_BUSY_IF, ARB_BUSY_D: begin
          if (done) begin
            mem_req <= 1'b0;
            state   <= ARB_IDLE;
            if (!mem_ready) mem_err <= 1'b1;
            if (state == ARB_BUSY_IF) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_ready ? mem_rdata : '0;
            end else begin
              d_rvalid <= 1'b1;
              d_rdata  <= (mem_ready && !we_q) ? mem_rdata : '0;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  arb_sat_counter #(.WIDTH(32)) u_perf_if (
    .clk(clk), .n_rst(n_rst), .clr(1'b0), .inc(if_win), .cnt(perf_if_cnt)
  );
  arb_sat_counter #(.WIDTH(32)) u_perf_d (
    .clk(clk), .n_rst(n_rst), .clr(1'b0), .inc(d_win), .cnt(perf_d_cnt)
  );
  arb_sat_counter #(.WIDTH(32)) u_perf_stall (
    .clk(clk), .n_rst(n_rst), .clr(1'b0), .inc(cpu_stall), .cnt(perf_stall_cnt)
  );
`else
  assign perf_if_cnt    = '0;
  assign perf_d_cnt     = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single accesses, corner sequences, random vs. model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;
  localparam int TMO   = 255;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_funct3;
  logic        mem_req, mem_we, mem_ready, mem_err, cpu_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;
  logic [31:0] perf_if_cnt, perf_d_cnt, perf_stall_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .clk(clk), .n_rst(n_rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_err(mem_err), .cpu_stall(cpu_stall),
    .perf_if_cnt(perf_if_cnt), .perf_d_cnt(perf_d_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_f3;
  } acc_t;

  acc_t tbl [6];

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_funct3 = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  // One complete access: grant at cycle 0, mem_ready at cycle lat, rvalid at lat+1.
  task automatic run_access(input acc_t a);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    if (a.is_d) begin
      d_req = 1'b1; d_we = a.we; d_addr = a.addr; d_wdata = a.wdata; d_funct3 = a.f3;
    end else begin
      if_req = 1'b1; if_addr = a.addr;
    end
    @(negedge clk);
    check_b("gnt", a.is_d ? d_gnt : if_gnt, 1'b1);
    check_b("gnt_other", a.is_d ? if_gnt : d_gnt, 1'b0);
    check_b("stall_c0", cpu_stall, 1'b1);
    for (int c = 1; c <= a.lat; c++) begin
      @(posedge clk); #1;
      mem_ready = (c == a.lat);
      mem_rdata = (c == a.lat) ? a.rdata : (32'hBAD0_0000 ^ 32'(c));
      if (a.is_d) begin
        d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom); d_funct3 = 3'($urandom);
      end else begin
        if_addr = $urandom;
      end
      @(negedge clk);
      if (c == 1) begin
        check_b("mem_req", mem_req, 1'b1);
        check("mem_addr", mem_addr, a.addr);
        check_b("mem_we", mem_we, a.is_d && a.we);
        check("mem_funct3", 32'(mem_funct3), 32'(a.exp_f3));
        if (a.is_d) check("mem_wdata", mem_wdata, a.wdata);
      end
      check_b("rv_early", a.is_d ? d_rvalid : if_rvalid, 1'b0);
      check_b("stall_busy", cpu_stall, 1'b1);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    if (a.is_d) d_req = 1'b0; else if_req = 1'b0;
    @(negedge clk);
    check_b("rvalid", a.is_d ? d_rvalid : if_rvalid, 1'b1);
    check("rdata", a.is_d ? d_rdata : if_rdata, a.exp_rdata);
    check_b("stall_done", cpu_stall, 1'b0);
    check_b("mem_req_done", mem_req, 1'b0);
  endtask

  // Random-phase reference model state
  bit          m_busy, m_is_d, m_we, rdy, eg_d, eg_i, if_pend, d_pend, rv_if, rv_d;
  logic [31:0] m_addr, m_wdata, e_if_rdata, e_d_rdata;
  logic [2:0]  m_f3;
  int          m_age, m_lat, starve;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];

  function automatic logic [31:0] seed_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_val(a);
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : seed_val(a);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    acc_t p;

    //        is_d we addr          wdata         f3      lat rdata         exp_rdata     exp_f3
    tbl[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        3'b000, 2, 32'h0050_0093, 32'h0050_0093, 3'b010};
    tbl[1] = '{1'b1, 1'b0, 32'h104, 32'h0,        3'b100, 1, 32'h1234_5678, 32'h1234_5678, 3'b100};
    tbl[2] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 3'b010, 3, 32'hFFFF_0000, 32'h0,         3'b010};
    tbl[3] = '{1'b0, 1'b0, 32'h44,  32'h0,        3'b111, 5, 32'hCAFE_F00D, 32'hCAFE_F00D, 3'b010};
    tbl[4] = '{1'b1, 1'b0, 32'h1FE, 32'h0,        3'b001, 1, 32'h0000_8001, 32'h0000_8001, 3'b001};
    tbl[5] = '{1'b1, 1'b1, 32'h300, 32'h0BAD_CAFE, 3'b000, 4, 32'h7777_7777, 32'h0,        3'b000};

    n_rst = 1'b0;
    idle_inputs();
    do_reset();

    // Reset state
    check_b("rst_mem_req", mem_req, 1'b0);
    check_b("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_funct3", 32'(mem_funct3), 32'h0);
    check_b("rst_if_rvalid", if_rvalid, 1'b0);
    check_b("rst_d_rvalid", d_rvalid, 1'b0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check_b("rst_mem_err", mem_err, 1'b0);
    check_b("rst_stall", cpu_stall, 1'b0);
    check_b("rst_gnts", if_gnt | d_gnt, 1'b0);

    for (int i = 0; i < 6; i++) run_access(tbl[i]);

    // Same-cycle fetch and store: data first, fetch granted alongside d_rvalid
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
    @(negedge clk);
    check_b("sc_d_gnt", d_gnt, 1'b1);
    check_b("sc_if_gnt0", if_gnt, 1'b0);
    @(posedge clk); #1; mem_ready = 1'b1;
    @(negedge clk);
    check_b("sc_mem_we", mem_we, 1'b1);
    check("sc_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("sc_mem_addr", mem_addr, 32'h200);
    @(posedge clk); #1; mem_ready = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check_b("sc_d_rvalid", d_rvalid, 1'b1);
    check("sc_d_rdata", d_rdata, 32'h0);
    check_b("sc_if_gnt1", if_gnt, 1'b1);
    @(posedge clk); #1; mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    check("sc_if_addr", mem_addr, 32'h40);
    check_b("sc_if_we", mem_we, 1'b0);
    check("sc_if_f3", 32'(mem_funct3), 32'(3'b010));
    @(posedge clk); #1; mem_ready = 1'b0; if_req = 1'b0;
    @(negedge clk);
    check_b("sc_if_rvalid", if_rvalid, 1'b1);
    check("sc_if_rdata", if_rdata, 32'h1111_2222);

    // Starvation guard: both held, memory always ready
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_funct3 = 3'b010;
    mem_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      check_b("st_slot", if_gnt | d_gnt, (c % 2) == 0);
      if ((c % 2) == 0) check_b("st_kind", if_gnt, ((c / 2) % 5) == 4);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;

    // Hung memory: abort at cycle 256 after the grant
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h88; mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_b("tmo_gnt", if_gnt, 1'b1);
    first = -1;
    for (int c = 1; c <= 300 && first < 0; c++) begin
      @(posedge clk); #1;
      if (if_rvalid) begin
        first = c;
        if_req = 1'b0;
      end
      @(negedge clk);
      if (c == 200) check_b("tmo_err_early", mem_err, 1'b0);
    end
    check("tmo_cycle", 32'(first), 32'd256);
    check("tmo_rdata", if_rdata, 32'h0);
    check_b("tmo_err", mem_err, 1'b1);
    run_access(tbl[1]);
    check_b("tmo_err_sticky", mem_err, 1'b1);
    do_reset();
    check_b("tmo_err_clr", mem_err, 1'b0);

    // Reset in the middle of a data access
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_funct3 = 3'b010;
    @(posedge clk); #1;
    check_b("mr_busy", mem_req, 1'b1);
    n_rst = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
    #1;
    check_b("mr_req0", mem_req, 1'b0);
    check("mr_addr0", mem_addr, 32'h0);
    check_b("mr_d_gnt0", d_gnt, 1'b0);
    check_b("mr_rv0", d_rvalid, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_b("mr_no_rv", d_rvalid, 1'b0);
      check_b("mr_no_req", mem_req, 1'b0);
    end
    mem_ready = 1'b0;
    run_access(tbl[4]);

    // Performance counters: 3 fetches and 2 loads at 1-cycle memory, 2 stall cycles each
    do_reset();
    for (int i = 0; i < 5; i++) begin
      p = '{(i >= 3), 1'b0, 32'(i * 4), 32'h0, 3'b010, 1, 32'(i), 32'(i), 3'b010};
      run_access(p);
    end
    @(posedge clk); #1;
    @(negedge clk);
`ifdef ARB_PERF_CNT_EN
    check("perf_if", perf_if_cnt, 32'd3);
    check("perf_d", perf_d_cnt, 32'd2);
    check("perf_stall", perf_stall_cnt, 32'd10);
`else
    check("perf_if_off", perf_if_cnt, 32'd0);
    check("perf_d_off", perf_d_cnt, 32'd0);
    check("perf_stall_off", perf_stall_cnt, 32'd0);
`endif

    // Random traffic against a transaction-level model
    do_reset();
    m_busy = 1'b0; rv_if = 1'b0; rv_d = 1'b0; starve = 0;
    e_if_rdata = '0; e_d_rdata = '0; if_pend = 1'b0; d_pend = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (rv_if) if_pend = 1'b0;
      if (rv_d) d_pend = 1'b0;
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1;
        if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!d_pend && $urandom_range(0, 3) != 0) begin
        d_pend = 1'b1;
        d_addr = 32'($urandom_range(0, 15)) << 2;
        d_we = 1'($urandom);
        d_wdata = $urandom;
        d_funct3 = 3'($urandom);
      end
      if_req = if_pend;
      d_req = d_pend;

      rdy = m_busy ? (m_age == m_lat) : 1'($urandom);
      mem_ready = rdy;
      mem_rdata = $urandom;
      if (m_busy && rdy) begin
        if (mem_we) dev_mem[mem_addr] = mem_wdata;
        else mem_rdata = dev_rd(mem_addr);
      end

      eg_d = !m_busy && d_pend && !(if_pend && starve == LIMIT);
      eg_i = !m_busy && !eg_d && if_pend;

      @(negedge clk);
      check_b("r_if_gnt", if_gnt, eg_i);
      check_b("r_d_gnt", d_gnt, eg_d);
      check_b("r_if_rv", if_rvalid, rv_if);
      check_b("r_d_rv", d_rvalid, rv_d);
      check("r_if_rdata", if_rdata, e_if_rdata);
      check("r_d_rdata", d_rdata, e_d_rdata);
      check_b("r_stall", cpu_stall, (if_pend && !rv_if) || (d_pend && !rv_d));
      check_b("r_mem_req", mem_req, m_busy);
      if (m_busy) begin
        check("r_mem_addr", mem_addr, m_addr);
        check_b("r_mem_we", mem_we, m_we);
        check("r_mem_f3", 32'(mem_funct3), 32'(m_f3));
        if (m_is_d) check("r_mem_wdata", mem_wdata, m_wdata);
      end

      rv_if = 1'b0;
      rv_d = 1'b0;
      if (m_busy) begin
        if (rdy) begin
          m_busy = 1'b0;
          if (!m_is_d) begin
            rv_if = 1'b1;
            e_if_rdata = ref_rd(m_addr);
          end else if (m_we) begin
            rv_d = 1'b1;
            e_d_rdata = '0;
            ref_mem[m_addr] = m_wdata;
          end else begin
            rv_d = 1'b1;
            e_d_rdata = ref_rd(m_addr);
          end
        end else begin
          m_age++;
        end
      end
      if (eg_d || eg_i) begin
        m_busy = 1'b1;
        m_is_d = eg_d;
        m_age = 1;
        m_lat = $urandom_range(1, 4);
        if (eg_d) begin
          m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_f3 = d_funct3;
        end else begin
          m_addr = if_addr; m_we = 1'b0; m_wdata = '0; m_f3 = 3'b010;
        end
      end
      if (!if_pend) starve = 0;
      else if (eg_i) starve = 0;
      else if (eg_d && starve < LIMIT) starve++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
